z80_bus_responder: RTL and testbench
====================================

Name: z80_bus_responder

Overview:
Target-side model of the Z80 external bus: the memory/I/O device the core talks to.
- Samples the core's strobes, address and write data on every rising clk edge.
- Classifies each bus cycle as memory read/write, I/O read/write, interrupt acknowledge or refresh.
- Services memory cycles through a synchronous memory port and I/O cycles through a request/acknowledge port.
- Drives READ_D and inserts wait states on nWAIT.
- Used in system benches and FPGA builds around z80.

Parameters:
MEM_WAIT, 0, nWAIT-low cycles inserted per memory cycle (0..7)
IO_WAIT, 1, minimum nWAIT-low cycles per I/O cycle (1..7)
IO_TIMEOUT, 16, cycles to wait for io_ack before aborting (2..255)
INTACK_VECTOR, 8'hFF, byte returned on interrupt acknowledge

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
nMREQ, nIORQ, nRD, nWR, nM1, nRFSH  input  1 each  core bus strobes, active low
A  input  16  core address bus
WRITE_D  input  8  core write data
nWAIT  output  1  wait request to core, active low, registered
READ_D  output  8  read data to core, registered
mem_en  output  1  one-cycle memory access strobe
mem_we  output  1  write qualifier for mem_en
mem_addr  output  16  memory address
mem_wdata  output  8  memory write data
mem_rdata  input  8  memory read data, valid the cycle after mem_en
io_req  output  1  I/O request, held until ack or timeout
io_we  output  1  I/O write qualifier
io_addr  output  8  A[7:0] latched at detect
io_wdata  output  8  I/O write data
io_rdata  input  8  I/O read data, valid with io_ack
io_ack  input  1  I/O completion, single-cycle pulse
bus_error  output  1  one-cycle pulse on protocol violation or I/O timeout

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, named reset.
- Reset values: nWAIT=1, READ_D=8'hFF, bus_error=0. mem_en, mem_we, io_req and io_we are 0. mem_addr, mem_wdata, io_addr and io_wdata are 0. State is IDLE.
- Reset mid-transaction: all outputs return to reset values immediately, including io_req. The transaction is discarded.
- Classification (in IDLE only, at detect edge E0), in priority order:
  - INTACK: !nM1 && !nIORQ.
  - REFRESH: !nMREQ && !nRFSH. Ignored; no access; stays IDLE.
  - MEM: !nMREQ && (!nRD || !nWR).
  - IO: !nIORQ && (!nRD || !nWR).
- Write qualifier: write = !nWR. If nRD and nWR are both low, write wins and bus_error pulses at E0+1.
- Conflicting strobes: nMREQ and nIORQ both low without nM1 low is handled as MEM, and bus_error pulses at E0+1.
- States: IDLE, MEM, IO, HOLD.
- IDLE to MEM (at E0):
  - mem_en<=1, mem_we<=write, mem_addr<=A, mem_wdata<=WRITE_D.
  - nWAIT<=(MEM_WAIT==0), cnt<=MEM_WAIT.
- MEM:
  - mem_en drops at E1.
  - For reads, READ_D<=mem_rdata at E2.
  - cnt decrements each edge while nonzero; nWAIT<=1 on the edge cnt reaches 0.
  - nWAIT is therefore low for exactly MEM_WAIT cycles starting at E0.
  - Go to HOLD at the later of E2 and cnt==0.
- IDLE to IO (at E0):
  - io_req<=1, io_we<=write, io_addr<=A[7:0], io_wdata<=WRITE_D.
  - nWAIT<=0; wait counter and timeout counter load.
- IO:
  - On the edge io_ack is sampled high: io_req<=0, and READ_D<=io_rdata for reads.
  - nWAIT<=1 on the later of the ack edge and IO_WAIT cycles after E0; then go to HOLD.
  - Timeout: if IO_TIMEOUT cycles elapse with no ack, io_req<=0, READ_D<=8'hFF, bus_error pulses, nWAIT<=1, go to HOLD.
  - An io_ack arriving while io_req==0 is ignored.
- INTACK (at E0): READ_D<=INTACK_VECTOR, nWAIT stays 1, go to HOLD.
- HOLD: stays until nMREQ and nIORQ are both sampled high, then IDLE. Result: exactly one transaction per strobe assertion.
- READ_D holds its last value between transactions. Writes never modify READ_D.
- Counters saturate and never wrap.

Decomposition:
- Package z80_bus_pkg:
  - cycle-type enum (NONE, MEM_RD, MEM_WR, IO_RD, IO_WR, INTACK, REFRESH).
  - responder state enum.
  - default INTACK_VECTOR constant.
- Sub-module z80_bus_decode: the combinational strobe-to-cycle-type classifier plus violation flag. The decoder is reusable by the bus monitor for formal checks.

Test Plan:
- Memory read, MEM_WAIT=0, A=16'h1234, mem_rdata=8'hA5 -> mem_en pulses 1 cycle with mem_addr=16'h1234; READ_D=8'hA5 at E2; nWAIT never low.
- Memory write, MEM_WAIT=2, WRITE_D=8'h3C -> mem_en && mem_we with mem_wdata=8'h3C; nWAIT low exactly 2 cycles; READ_D unchanged.
- I/O read, A=16'h00FE, io_ack at E0+5 with io_rdata=8'h5A -> io_addr=8'hFE; io_req high 5 cycles; READ_D=8'h5A; nWAIT high at E0+6.
- I/O with no ack, IO_TIMEOUT=16 -> io_req drops at E0+16; bus_error 1-cycle pulse; READ_D=8'hFF; nWAIT released.
- Interrupt acknowledge (nM1 and nIORQ low) then a refresh cycle (nMREQ and nRFSH low) -> READ_D=8'hFF with no wait; refresh produces no mem_en.
- Reset asserted while in IO with io_req=1 -> io_req=0 and nWAIT=1 immediately; after release, the next memory read completes normally.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder and any bus monitor that reuses the decoder.
//   cycle_e : classified bus cycle type
//   state_e : responder transaction state
package z80_bus_pkg;

  typedef enum logic [2:0] {
    CycNone,
    CycMemRd,
    CycMemWr,
    CycIoRd,
    CycIoWr,
    CycIntack,
    CycRefresh
  } cycle_e;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StIo,
    StHold
  } state_e;

  localparam logic [7:0] IntackVectorDefault = 8'hFF;

endpackage

// File: rtl/z80_bus_decode.sv
// Combinational classifier: maps the Z80 bus strobes to a cycle type and flags
// strobe combinations that violate the bus protocol.
//   n_*_i   : active-low core strobes
//   cycle_o : cycle type, in priority INTACK > REFRESH > MEM > IO
//   viol_o  : nRD and nWR both low, or nMREQ and nIORQ both low outside INTACK
module z80_bus_decode
  import z80_bus_pkg::*;
(
  input  logic   n_mreq_i,
  input  logic   n_iorq_i,
  input  logic   n_rd_i,
  input  logic   n_wr_i,
  input  logic   n_m1_i,
  input  logic   n_rfsh_i,
  output cycle_e cycle_o,
  output logic   viol_o
);

  logic access;
  logic rw_both;

  assign access  = !n_rd_i || !n_wr_i;
  assign rw_both = !n_rd_i && !n_wr_i;

  always_comb begin
    cycle_o = CycNone;
    viol_o  = 1'b0;
    if (!n_m1_i && !n_iorq_i) begin
      cycle_o = CycIntack;
    end else if (!n_mreq_i && !n_rfsh_i) begin
      cycle_o = CycRefresh;
    end else if (!n_mreq_i && access) begin
      // Write wins over read; a simultaneous nIORQ is serviced as memory.
      cycle_o = !n_wr_i ? CycMemWr : CycMemRd;
      viol_o  = rw_both || !n_iorq_i;
    end else if (!n_iorq_i && access) begin
      cycle_o = !n_wr_i ? CycIoWr : CycIoRd;
      viol_o  = rw_both;
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Target-side Z80 bus model. Classifies each strobe assertion once, services it
// through a synchronous memory port or an I/O req/ack port, drives READ_D and
// stretches the cycle with nWAIT.
//   clk, reset                 : clock, async active-high reset
//   nMREQ..nRFSH, A, WRITE_D   : core bus inputs
//   nWAIT, READ_D              : registered responses to the core
//   mem_*                      : one-cycle strobed memory port, rdata one cycle later
//   io_*                       : held request until io_ack pulse or timeout
//   bus_error                  : one-cycle pulse on protocol violation or I/O timeout
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT      = 0,
  parameter int unsigned IO_WAIT       = 1,
  parameter int unsigned IO_TIMEOUT    = 16,
  parameter logic [7:0]  INTACK_VECTOR = IntackVectorDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  input  logic        nRFSH,
  input  logic [15:0] A,
  input  logic [7:0]  WRITE_D,
  output logic        nWAIT,
  output logic [7:0]  READ_D,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        bus_error
);

  cycle_e cycle;
  logic   viol;

  z80_bus_decode u_decode (
    .n_mreq_i (nMREQ),
    .n_iorq_i (nIORQ),
    .n_rd_i   (nRD),
    .n_wr_i   (nWR),
    .n_m1_i   (nM1),
    .n_rfsh_i (nRFSH),
    .cycle_o  (cycle),
    .viol_o   (viol)
  );

  state_e      state_q, state_d;
  logic [1:0]  ph_q, ph_d;         // edges since E0 in MEM, saturating at 2
  logic [2:0]  wcnt_q, wcnt_d;     // remaining nWAIT-low cycles
  logic [7:0]  tcnt_q, tcnt_d;     // remaining cycles before I/O timeout
  logic        ack_seen_q, ack_seen_d;
  logic        viol_q, viol_d;     // delays decode violation to E0+1
  logic        nwait_q, nwait_d;
  logic [7:0]  read_q, read_d;
  logic        bus_error_q, bus_error_d;
  logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        io_req_q, io_req_d, io_we_q, io_we_d;
  logic [7:0]  io_addr_q, io_addr_d, io_wdata_q, io_wdata_d;

  logic [2:0]  wcnt_dec;
  logic [7:0]  tcnt_dec;
  logic        ack_now;

  assign wcnt_dec = (wcnt_q != 3'd0) ? wcnt_q - 3'd1 : 3'd0;
  assign tcnt_dec = (tcnt_q != 8'd0) ? tcnt_q - 8'd1 : 8'd0;
  assign ack_now  = io_ack && io_req_q;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    ack_seen_d  = ack_seen_q;
    viol_d      = 1'b0;
    nwait_d     = nwait_q;
    read_d      = read_q;
    bus_error_d = viol_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    io_req_d    = io_req_q;
    io_we_d     = io_we_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;

    unique case (state_q)
      StIdle: begin
        unique case (cycle)
          CycIntack: begin
            read_d  = INTACK_VECTOR;
            state_d = StHold;
          end
          CycMemRd, CycMemWr: begin
            mem_en_d    = 1'b1;
            mem_we_d    = (cycle == CycMemWr);
            mem_addr_d  = A;
            mem_wdata_d = WRITE_D;
            nwait_d     = (MEM_WAIT == 0);
            wcnt_d      = 3'(MEM_WAIT);
            ph_d        = 2'd0;
            viol_d      = viol;
            state_d     = StMem;
          end
          CycIoRd, CycIoWr: begin
            io_req_d   = 1'b1;
            io_we_d    = (cycle == CycIoWr);
            io_addr_d  = A[7:0];
            io_wdata_d = WRITE_D;
            nwait_d    = 1'b0;
            wcnt_d     = 3'(IO_WAIT);
            tcnt_d     = 8'(IO_TIMEOUT);
            ack_seen_d = 1'b0;
            viol_d     = viol;
            state_d    = StIo;
          end
          default: ;  // idle bus and refresh need no response
        endcase
      end
      StMem: begin
        wcnt_d = wcnt_dec;
        if (wcnt_dec == 3'd0) nwait_d = 1'b1;
        // rdata is valid the cycle after mem_en, i.e. at E2.
        if (ph_q == 2'd1 && !mem_we_q) read_d = mem_rdata;
        if (ph_q != 2'd2) ph_d = ph_q + 2'd1;
        if (ph_q != 2'd0 && wcnt_dec == 3'd0) state_d = StHold;
      end
      StIo: begin
        wcnt_d = wcnt_dec;
        tcnt_d = tcnt_dec;
        if (ack_now) begin
          io_req_d   = 1'b0;
          ack_seen_d = 1'b1;
          if (!io_we_q) read_d = io_rdata;
        end
        if ((ack_seen_q || ack_now) && wcnt_dec == 3'd0) begin
          nwait_d = 1'b1;
          state_d = StHold;
        end else if (!ack_seen_q && !ack_now && tcnt_dec == 8'd0) begin
          io_req_d    = 1'b0;
          read_d      = 8'hFF;
          bus_error_d = 1'b1;
          nwait_d     = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (nMREQ && nIORQ) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ph_q        <= 2'd0;
      wcnt_q      <= 3'd0;
      tcnt_q      <= 8'd0;
      ack_seen_q  <= 1'b0;
      viol_q      <= 1'b0;
      nwait_q     <= 1'b1;
      read_q      <= 8'hFF;
      bus_error_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= 8'h00;
      io_wdata_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      ack_seen_q  <= ack_seen_d;
      viol_q      <= viol_d;
      nwait_q     <= nwait_d;
      read_q      <= read_d;
      bus_error_q <= bus_error_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      io_req_q    <= io_req_d;
      io_we_q     <= io_we_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
    end
  end

  assign nWAIT     = nwait_q;
  assign READ_D    = read_q;
  assign bus_error = bus_error_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: dut0 uses MEM_WAIT=0, dut2 uses MEM_WAIT=2,
// both share the same bus stimulus. Outputs are sampled 1 ns after each rising edge.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        n_mreq = 1'b1, n_iorq = 1'b1, n_rd = 1'b1, n_wr = 1'b1;
  logic        n_m1 = 1'b1, n_rfsh = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  io_rdata = 8'h00;
  logic        io_ack = 1'b0;

  logic        nwait0, mem_en0, mem_we0, io_req0, io_we0, berr0;
  logic [7:0]  read_d0, mem_wdata0, io_addr0, io_wdata0;
  logic [15:0] mem_addr0;
  logic        nwait2, mem_en2, mem_we2, io_req2, io_we2, berr2;
  logic [7:0]  read_d2, mem_wdata2, io_addr2, io_wdata2;
  logic [15:0] mem_addr2;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  z80_bus_responder #(.MEM_WAIT(0), .IO_WAIT(1), .IO_TIMEOUT(16)) dut0 (
    .clk(clk), .reset(reset), .nMREQ(n_mreq), .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr),
    .nM1(n_m1), .nRFSH(n_rfsh), .A(addr), .WRITE_D(wdata), .nWAIT(nwait0), .READ_D(read_d0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata), .io_req(io_req0), .io_we(io_we0), .io_addr(io_addr0),
    .io_wdata(io_wdata0), .io_rdata(io_rdata), .io_ack(io_ack), .bus_error(berr0)
  );

  z80_bus_responder #(.MEM_WAIT(2), .IO_WAIT(1), .IO_TIMEOUT(16)) dut2 (
    .clk(clk), .reset(reset), .nMREQ(n_mreq), .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr),
    .nM1(n_m1), .nRFSH(n_rfsh), .A(addr), .WRITE_D(wdata), .nWAIT(nwait2), .READ_D(read_d2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata), .io_req(io_req2), .io_we(io_we2), .io_addr(io_addr2),
    .io_wdata(io_wdata2), .io_rdata(io_rdata), .io_ack(io_ack), .bus_error(berr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release all strobes and give the responder time to leave HOLD.
  task automatic bus_idle();
    n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_m1 = 1'b1; n_rfsh = 1'b1;
    step();
    step();
  endtask

  initial begin
    #12;
    check("rst_nwait", nwait0, 1'b1);
    check("rst_read_d", read_d0, 8'hFF);
    check("rst_berr", berr0, 1'b0);
    check("rst_mem_en", mem_en0, 1'b0);
    check("rst_io_req", io_req0, 1'b0);
    check("rst_mem_addr", mem_addr0, 16'h0000);
    reset = 1'b0;
    step();

    // Memory read, no wait states on dut0.
    addr = 16'h1234; mem_rdata = 8'hA5; n_mreq = 1'b0; n_rd = 1'b0;
    step();  // E0
    check("mrd_e0_en", mem_en0, 1'b1);
    check("mrd_e0_addr", mem_addr0, 16'h1234);
    check("mrd_e0_we", mem_we0, 1'b0);
    check("mrd_e0_nwait", nwait0, 1'b1);
    step();  // E1
    check("mrd_e1_en", mem_en0, 1'b0);
    check("mrd_e1_nwait", nwait0, 1'b1);
    step();  // E2
    check("mrd_e2_read", read_d0, 8'hA5);
    check("mrd_e2_read_w2", read_d2, 8'hA5);
    bus_idle();

    // Memory write, two wait states on dut2; READ_D must stay A5.
    addr = 16'h4000; wdata = 8'h3C; mem_rdata = 8'h77; n_mreq = 1'b0; n_wr = 1'b0;
    step();  // E0
    check("mwr_e0_en", mem_en2, 1'b1);
    check("mwr_e0_we", mem_we2, 1'b1);
    check("mwr_e0_wdata", mem_wdata2, 8'h3C);
    check("mwr_e0_nwait", nwait2, 1'b0);
    step();  // E1
    check("mwr_e1_nwait", nwait2, 1'b0);
    check("mwr_e1_en", mem_en2, 1'b0);
    step();  // E2
    check("mwr_e2_nwait", nwait2, 1'b1);
    check("mwr_read_kept", read_d2, 8'hA5);
    bus_idle();

    // I/O read with io_ack sampled at E0+5.
    addr = 16'h00FE; io_rdata = 8'h5A; n_iorq = 1'b0; n_rd = 1'b0;
    step();  // E0
    check("iord_e0_req", io_req0, 1'b1);
    check("iord_e0_addr", io_addr0, 8'hFE);
    check("iord_e0_we", io_we0, 1'b0);
    check("iord_e0_nwait", nwait0, 1'b0);
    for (int i = 0; i < 4; i++) step();  // E0+4
    check("iord_e4_req", io_req0, 1'b1);
    check("iord_e4_nwait", nwait0, 1'b0);
    io_ack = 1'b1;
    step();  // E0+5
    io_ack = 1'b0;
    check("iord_e5_req", io_req0, 1'b0);
    check("iord_e5_read", read_d0, 8'h5A);
    step();  // E0+6
    check("iord_e6_nwait", nwait0, 1'b1);
    bus_idle();

    // Interrupt acknowledge, then a refresh cycle.
    n_m1 = 1'b0; n_iorq = 1'b0;
    step();
    check("intack_read", read_d0, 8'hFF);
    check("intack_nwait", nwait0, 1'b1);
    check("intack_io_req", io_req0, 1'b0);
    bus_idle();
    n_mreq = 1'b0; n_rfsh = 1'b0;
    step();
    check("rfsh_e0_en", mem_en0, 1'b0);
    check("rfsh_e0_nwait", nwait0, 1'b1);
    step();
    check("rfsh_e1_en", mem_en0, 1'b0);
    bus_idle();

    // Reset during an outstanding I/O request.
    addr = 16'h0020; n_iorq = 1'b0; n_rd = 1'b0;
    step();
    step();
    check("rstio_req_before", io_req0, 1'b1);
    reset = 1'b1;
    #1;
    check("rstio_req", io_req0, 1'b0);
    check("rstio_nwait", nwait0, 1'b1);
    n_iorq = 1'b1; n_rd = 1'b1;
    step();
    reset = 1'b0;
    step();
    addr = 16'h0ABC; mem_rdata = 8'h42; n_mreq = 1'b0; n_rd = 1'b0;
    step();  // E0
    check("rstio_mrd_en", mem_en0, 1'b1);
    check("rstio_mrd_addr", mem_addr0, 16'h0ABC);
    step();
    step();  // E2
    check("rstio_mrd_read", read_d0, 8'h42);
    bus_idle();

    // I/O read with no acknowledge: timeout at E0+16.
    addr = 16'h0010; n_iorq = 1'b0; n_rd = 1'b0;
    step();  // E0
    check("tmo_e0_req", io_req0, 1'b1);
    for (int i = 0; i < 15; i++) step();  // E0+15
    check("tmo_e15_req", io_req0, 1'b1);
    check("tmo_e15_nwait", nwait0, 1'b0);
    check("tmo_e15_berr", berr0, 1'b0);
    step();  // E0+16
    check("tmo_e16_req", io_req0, 1'b0);
    check("tmo_e16_berr", berr0, 1'b1);
    check("tmo_e16_read", read_d0, 8'hFF);
    check("tmo_e16_nwait", nwait0, 1'b1);
    step();
    check("tmo_e17_berr", berr0, 1'b0);
    bus_idle();

    // Stray io_ack while idle must not disturb anything.
    io_ack = 1'b1; io_rdata = 8'h11;
    step();
    io_ack = 1'b0;
    check("stray_ack_read", read_d0, 8'hFF);

    // nRD and nWR both low on a memory cycle: write wins, error at E0+1.
    addr = 16'h2000; wdata = 8'h11; n_mreq = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
    step();  // E0
    check("rw_e0_we", mem_we0, 1'b1);
    check("rw_e0_berr", berr0, 1'b0);
    step();  // E0+1
    check("rw_e1_berr", berr0, 1'b1);
    step();
    check("rw_e2_berr", berr0, 1'b0);
    check("rw_read_kept", read_d0, 8'hFF);
    bus_idle();

    // Memory and I/O strobes together: serviced as memory with an error.
    addr = 16'h3000; n_mreq = 1'b0; n_iorq = 1'b0; n_rd = 1'b0;
    step();
    check("mix_e0_en", mem_en0, 1'b1);
    check("mix_e0_io_req", io_req0, 1'b0);
    step();
    check("mix_e1_berr", berr0, 1'b1);
    bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
